// File: rtl/dna_pkg.sv
// Shared constants, state names and the CRC-7 helper for the device-ID port
// responder and its checker.
package dna_pkg;

   localparam int DNA_ID_W     = 57;
   localparam int DNA_CRC_W    = 7;
   localparam int DNA_MAX_ID_W = 120;

   localparam logic [DNA_ID_W-1:0] DNA_ID_DEFAULT = 57'h0_0000_0000_0000_01;

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_LOADED,
      ST_SHIFTING,
      ST_DRAINED
   } dna_state_e;

   // CRC-7 (x^7+x^3+1, init 0), MSB-first over the low 'width' bits of data.
   function automatic logic [DNA_CRC_W-1:0] crc7(input logic [DNA_MAX_ID_W-1:0] data,
                                                 input int width);
      logic [DNA_CRC_W-1:0] crc;
      logic                 fb;
      crc = '0;
      for (int i = DNA_MAX_ID_W - 1; i >= 0; i--) begin
         if (i < width) begin
            fb  = data[i] ^ crc[DNA_CRC_W-1];
            crc = {crc[DNA_CRC_W-2:0], 1'b0};
            if (fb) begin
               crc = crc ^ 7'h09;
            end
         end
      end
      return crc;
   endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for a clock line plus a data bus, with a one-cycle
// pulse on each rising edge of the synchronised clock line.
module sync_edge #(
   parameter int W      = 1,
   parameter int STAGES = 2
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clk_line_i,
   input  logic [W-1:0] data_i,
   output logic [W-1:0] data_o,
   output logic         edge_o
);

   logic [STAGES-1:0]        clkPipe_q;
   logic [STAGES-1:0][W-1:0] dataPipe_q;
   logic                     clkPrev_q;

   // Clock line and data share the same depth so they stay mutually aligned.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         clkPipe_q  <= '0;
         dataPipe_q <= '0;
         clkPrev_q  <= 1'b0;
      end else begin
         clkPipe_q  <= {clkPipe_q[STAGES-2:0], clk_line_i};
         dataPipe_q <= {dataPipe_q[STAGES-2:0], data_i};
         clkPrev_q  <= clkPipe_q[STAGES-1];
      end
   end

   assign data_o = dataPipe_q[STAGES-1];
   assign edge_o = clkPipe_q[STAGES-1] & ~clkPrev_q;

endmodule

// File: rtl/dna_port_resp.sv
// Serial device-ID port responder: loads a fixed ID on READ and shifts it out
// MSB-first. Define DNA_CRC_EN to append a CRC-7 of the ID to the shifted word.
module dna_port_resp
   import dna_pkg::*;
#(
   parameter int              ID_W        = DNA_ID_W,
   parameter logic [ID_W-1:0] DNA_ID      = ID_W'(DNA_ID_DEFAULT),
   parameter int              SYNC_STAGES = 2
) (
   input  logic       clk4,
   input  logic       reset,
   input  logic       dna_clk,
   input  logic       dna_read,
   input  logic       dna_shift,
   input  logic       dna_din,
   output logic       dna_dout,
   output logic       loaded,
   output logic       drained,
   output logic [6:0] bit_cnt
);

`ifdef DNA_CRC_EN
   localparam int              SR_W      = ID_W + DNA_CRC_W;
   localparam logic [SR_W-1:0] LOAD_WORD = {DNA_ID, crc7(DNA_MAX_ID_W'(DNA_ID), ID_W)};
`else
   localparam int              SR_W      = ID_W;
   localparam logic [SR_W-1:0] LOAD_WORD = DNA_ID;
`endif
   localparam logic [6:0] CNT_MAX = 7'(SR_W);

   logic       dnaEdge;
   logic [2:0] syncData;
   logic       readSync;
   logic       shiftSync;
   logic       dinSync;

   logic [SR_W-1:0] sr_q, sr_d;
   logic [6:0]      cnt_q, cnt_d;
   logic            loaded_q, loaded_d;
   logic            drained_q, drained_d;
   dna_state_e      state;

   sync_edge #(
      .W      (3),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_i      (clk4),
      .rst_ni     (reset),
      .clk_line_i (dna_clk),
      .data_i     ({dna_din, dna_shift, dna_read}),
      .data_o     (syncData),
      .edge_o     (dnaEdge)
   );

   assign readSync  = syncData[0];
   assign shiftSync = syncData[1];
   assign dinSync   = syncData[2];

   always_ff @(posedge clk4 or negedge reset) begin
      if (!reset) begin
         sr_q      <= '0;
         cnt_q     <= '0;
         loaded_q  <= 1'b0;
         drained_q <= 1'b0;
      end else begin
         sr_q      <= sr_d;
         cnt_q     <= cnt_d;
         loaded_q  <= loaded_d;
         drained_q <= drained_d;
      end
   end

   // The protocol state is implied by the status flags and the counter.
   always_comb begin
      if (!loaded_q) begin
         state = ST_EMPTY;
      end else if (drained_q) begin
         state = ST_DRAINED;
      end else if (cnt_q == 7'd0) begin
         state = ST_LOADED;
      end else begin
         state = ST_SHIFTING;
      end
   end

   always_comb begin
      sr_d      = sr_q;
      cnt_d     = cnt_q;
      loaded_d  = loaded_q;
      drained_d = drained_q;
      if (dnaEdge) begin
         if (readSync) begin
            sr_d      = LOAD_WORD;
            cnt_d     = 7'd0;
            loaded_d  = 1'b1;
            drained_d = 1'b0;
         end else if (shiftSync) begin
            sr_d = {sr_q[SR_W-2:0], dinSync};
            // Only a loaded word is counted; EMPTY and DRAINED just move bits.
            case (state)
               ST_LOADED, ST_SHIFTING: begin
                  cnt_d = cnt_q + 7'd1;
                  if (cnt_q + 7'd1 == CNT_MAX) begin
                     drained_d = 1'b1;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign dna_dout = sr_q[SR_W-1];
   assign loaded   = loaded_q;
   assign drained  = drained_q;
   assign bit_cnt  = cnt_q;

endmodule

// File: tb/tb_dna_port_resp.sv
// Directed/randomised bench for dna_port_resp against a queue-based model of
// the ID shift word.
module tb_dna_port_resp;

   localparam int              ID_W        = 57;
   localparam int              SYNC_STAGES = 2;
   localparam logic [ID_W-1:0] TEST_ID     = 57'h1_2345_6789_ABCD_EF;
`ifdef DNA_CRC_EN
   localparam int SR_W = ID_W + 7;
`else
   localparam int SR_W = ID_W;
`endif

   logic       clk4;
   logic       reset;
   logic       dnaClk;
   logic       dnaRead;
   logic       dnaShift;
   logic       dnaDin;
   logic       dnaDout;
   logic       loaded;
   logic       drained;
   logic [6:0] bitCnt;

   int errors;
   int checks;

   bit              modelQ[$];
   int              modelCnt;
   bit              modelLoaded;
   bit              modelDrained;
   logic [SR_W-1:0] expWord;

   dna_port_resp #(
      .ID_W        (ID_W),
      .DNA_ID      (TEST_ID),
      .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .clk4      (clk4),
      .reset     (reset),
      .dna_clk   (dnaClk),
      .dna_read  (dnaRead),
      .dna_shift (dnaShift),
      .dna_din   (dnaDin),
      .dna_dout  (dnaDout),
      .loaded    (loaded),
      .drained   (drained),
      .bit_cnt   (bitCnt)
   );

   initial clk4 = 1'b0;
   always #5 clk4 = ~clk4;

   // Polynomial long division of {id, 7'b0} by x^7+x^3+1.
   function automatic logic [6:0] tbCrc(input logic [ID_W-1:0] id);
      logic [ID_W+6:0] v;
      v = {id, 7'b0};
      for (int i = ID_W + 6; i >= 7; i--) begin
         if (v[i]) begin
            v[i -: 8] = v[i -: 8] ^ 8'h89;
         end
      end
      return v[6:0];
   endfunction

   task automatic modelReset();
      modelQ.delete();
      for (int i = 0; i < SR_W; i++) modelQ.push_back(1'b0);
      modelCnt     = 0;
      modelLoaded  = 1'b0;
      modelDrained = 1'b0;
   endtask

   task automatic modelRead();
      modelQ.delete();
      for (int i = SR_W - 1; i >= 0; i--) modelQ.push_back(expWord[i]);
      modelCnt     = 0;
      modelLoaded  = 1'b1;
      modelDrained = 1'b0;
   endtask

   task automatic modelShift(input bit di);
      void'(modelQ.pop_front());
      modelQ.push_back(di);
      if (modelLoaded) begin
         if (modelCnt < SR_W) modelCnt = modelCnt + 1;
         if (modelCnt == SR_W) modelDrained = 1'b1;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic checkModel(input string tag);
      checkOutput({tag, ".dout"},    8'(dnaDout), 8'(modelQ[0]));
      checkOutput({tag, ".cnt"},     8'(bitCnt),  8'(modelCnt));
      checkOutput({tag, ".loaded"},  8'(loaded),  8'(modelLoaded));
      checkOutput({tag, ".drained"}, 8'(drained), 8'(modelDrained));
   endtask

   // One full dna_clk period with read/shift/din held stable around the rise.
   task automatic applyStimulus(input bit rd, input bit sh, input bit di);
      @(negedge clk4);
      dnaRead  = rd;
      dnaShift = sh;
      dnaDin   = di;
      repeat (5) @(negedge clk4);
      dnaClk = 1'b1;
      repeat (5) @(negedge clk4);
      dnaClk = 1'b0;
      if (rd) modelRead();
      else if (sh) modelShift(di);
   endtask

   task automatic readWithLatency();
      @(negedge clk4);
      dnaRead  = 1'b1;
      dnaShift = 1'b0;
      dnaDin   = 1'b0;
      repeat (5) @(negedge clk4);
      dnaClk = 1'b1;
      repeat (2) @(negedge clk4);
      checkOutput("latency.edge2", 8'(dnaDout), 8'd0);
      @(negedge clk4);
      checkOutput("latency.edge3", 8'(dnaDout), 8'(expWord[SR_W-1]));
      repeat (2) @(negedge clk4);
      dnaClk = 1'b0;
      modelRead();
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      bit di;
      errors   = 0;
      checks   = 0;
      reset    = 1'b0;
      dnaClk   = 1'b0;
      dnaRead  = 1'b0;
      dnaShift = 1'b0;
      dnaDin   = 1'b0;
`ifdef DNA_CRC_EN
      expWord = {TEST_ID, tbCrc(TEST_ID)};
`else
      expWord = TEST_ID;
`endif
      modelReset();

      repeat (3) @(negedge clk4);
      checkModel("reset");
      reset = 1'b1;
      repeat (8) @(negedge clk4);
      checkModel("idle");

      for (int i = 0; i < 3; i++) begin
         di = 1'($urandom_range(0, 1));
         applyStimulus(1'b0, 1'b1, di);
         checkModel("preread");
      end

      readWithLatency();
      checkModel("read");

      for (int i = 0; i < SR_W; i++) begin
         checkOutput("stream.bit", 8'(dnaDout), 8'(expWord[SR_W-1-i]));
         applyStimulus(1'b0, 1'b1, 1'b0);
         checkModel("stream");
      end

      applyStimulus(1'b1, 1'b1, 1'b1);
      checkModel("rdshift");
      checkOutput("rdshift.msb", 8'(dnaDout), 8'(TEST_ID[ID_W-1]));

      n = $urandom_range(1, SR_W - 1);
      for (int i = 0; i < n; i++) begin
         di = 1'($urandom_range(0, 1));
         applyStimulus(1'b0, 1'b1, di);
         checkModel("partial");
      end
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkModel("reload");

      for (int i = 0; i < SR_W; i++) begin
         applyStimulus(1'b0, 1'b1, dnaDout);
         checkModel("loop");
      end
      for (int i = 0; i < SR_W; i++) begin
         checkOutput("loop.restored", 8'(dnaDout), 8'(expWord[SR_W-1-i]));
         applyStimulus(1'b0, 1'b1, dnaDout);
      end
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b1, dnaDout);
         checkModel("loop.sat");
         checkOutput("loop.satcnt", 8'(bitCnt), 8'(SR_W));
      end

      applyStimulus(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         di = 1'($urandom_range(0, 1));
         applyStimulus(1'b0, 1'b1, di);
      end
      checkModel("pre_reset");
      checkOutput("pre_reset.cnt20", 8'(bitCnt), 8'd20);
      @(negedge clk4);
      #1 reset = 1'b0;
      #1;
      checkOutput("midreset.dout",    8'(dnaDout), 8'd0);
      checkOutput("midreset.cnt",     8'(bitCnt),  8'd0);
      checkOutput("midreset.loaded",  8'(loaded),  8'd0);
      checkOutput("midreset.drained", 8'(drained), 8'd0);
      modelReset();
      @(negedge clk4);
      reset = 1'b1;
      repeat (4) @(negedge clk4);
      checkModel("post_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dna_port_resp.md
Name: dna_port_resp

Overview:
- Synchronous responder for the serial device-ID port protocol (dna_clk / dna_read / dna_shift / dna_din / dna_dout).
- Used by the DNA reader front end to emulate the on-die ID primitive, for bench bring-up and for parts without one.
- Holds a fixed ID, loads it on a READ, then shifts it out MSB-first, one bit per dna_clk rising edge. Shifts dna_din into the LSB.
- Runs entirely on clk4; all protocol inputs are asynchronous to it and are synchronised internally.

Parameters:
- DNA_ID, 57'h0_0000_0000_0000_01, fixed device ID presented on READ.
- ID_W, 57, ID width in bits; must be 2..120.
- SYNC_STAGES, 2, synchroniser depth on protocol inputs; minimum 2.

Ports:
- clk4  in  1  system clock; all state on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- dna_clk  in  1  serial clock from the initiator; asynchronous.
- dna_read  in  1  load request, sampled on a dna_clk rising edge.
- dna_shift  in  1  shift request, sampled on a dna_clk rising edge.
- dna_din  in  1  serial data in, shifted into the LSB.
- dna_dout  out  1  serial data out; always the MSB of the shift register.
- loaded  out  1  set once a READ has occurred since reset.
- drained  out  1  set once SR_W bits have been shifted since the last READ.
- bit_cnt  out  7  shifts since the last READ; saturates at SR_W.

Behaviour:
- Clock and reset: one clock, clk4. Reset is asynchronous and active-low.
- Reset values: dna_dout=0, loaded=0, drained=0, bit_cnt=0, shift register all zero, synchroniser and edge flops 0, state EMPTY.
- SR_W: equals ID_W, or ID_W+7 with DNA_CRC_EN.
- Synchronisation: dna_clk, dna_read, dna_shift and dna_din each pass through SYNC_STAGES flops, so they stay mutually aligned.
- Edge detect: edge = clk_sync & ~clk_prev. One clk4-cycle pulse per dna_clk rise.
- Initiator timing: dna_clk high and low phases must each be at least SYNC_STAGES+2 clk4 periods. Read/shift/din must be stable for the same window around each dna_clk rise. Faster or glitchy clocks are outside spec; no recovery logic is required.
- Latency: register updates on the clk4 edge after the one on which edge is asserted. With SYNC_STAGES=2, dna_dout changes on the 3rd clk4 rising edge after dna_clk is first sampled high.
- Action priority, applied only on an edge cycle:
  - read=1: load shift register with DNA_ID (left-justified; CRC in the low bits with DNA_CRC_EN). bit_cnt=0, drained=0, loaded=1. Read wins over a simultaneous shift.
  - read=0, shift=1: shift register <= {sr[SR_W-2:0], din}.
  - read=0, shift=0: hold.
  - No edge: hold everything.
- States (encoded from loaded/drained; no separate state register required):
  - EMPTY: loaded=0. Shifts move the register (zeros plus din) but bit_cnt stays 0. READ -> LOADED.
  - LOADED: loaded=1, bit_cnt=0. Shift -> SHIFTING. READ -> LOADED (reload).
  - SHIFTING: 0<bit_cnt<SR_W; bit_cnt+1 per shift. When bit_cnt reaches SR_W -> DRAINED.
  - DRAINED: drained=1, bit_cnt stays at SR_W. Further shifts keep moving din through the register. READ -> LOADED.
- Wrap-around: din is shifted in, so after SR_W shifts with din tied to dout the register returns to the original ID. bit_cnt still saturates.
- Reset mid-shift: immediate return to EMPTY; the partial word is lost; dna_dout=0.
- Arithmetic: bit_cnt is 7 bits, saturating, never wraps.

Optional Feature:
- Macro: DNA_CRC_EN.
- Defined: SR_W=ID_W+7. On READ the register loads {DNA_ID, crc7}, where crc7 is CRC-7 (poly x^7+x^3+1, init 0, MSB-first over DNA_ID). crc7 is computed by a constant function at elaboration, so no runtime logic is added. The initiator receives a 64-bit word for ID_W=57.
- Undefined: SR_W=ID_W; no check bits.

Decomposition:
- Shared package dna_pkg:
  - DNA_ID_W=57 and DNA_CRC_W=7.
  - Default ID constant.
  - crc7 constant function, shared with the checker side.
- Sub-module sync_edge: SYNC_STAGES-deep synchroniser plus rising-edge pulse. Instantiated once for dna_clk; read/shift/din use the same parameterised synchroniser without the edge output.

Test Plan:
- Reset then idle -> dna_dout=0, loaded=0, drained=0, bit_cnt=0. Assert reset while SHIFTING at bit_cnt=20 -> all outputs 0 within the same cycle.
- DNA_ID=57'h1_2345_6789_ABCD_EF, READ then 57 shifts with din=0 -> serial stream equals the ID MSB-first. bit_cnt runs 1..57; drained rises on the 57th shift; dna_dout=0 afterwards.
- READ and shift both high on one dna_clk edge -> load only; bit_cnt=0; dna_dout = ID bit 56.
- Shifts before any READ -> loaded=0, bit_cnt=0. A later READ -> loaded=1, and the ID streams out correctly.
- din looped to dout, 60 shifts -> bit_cnt saturates at 57. After exactly 57 shifts the register equals the ID again.
- DNA_CRC_EN with ID 57'h0 -> 64 bits out: 57 zeros then 7'h00. With ID 57'h1 -> last 7 bits equal 7'h09 (x^3+1).
